// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared constants for the alarm time-keeping counters
package alarm_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

endpackage

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-N up/down counter with clear, load, saturate and cascade outputs
module mod_updown_counter
  import alarm_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MODULUS   = 60,
  parameter int SATURATE  = MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             at_limit
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) ||
      RESET_VAL < 0 || RESET_VAL >= MODULUS ||
      (SATURATE != MODE_WRAP && SATURATE != MODE_SAT)) begin : g_bad_params
    $error("mod_updown_counter: illegal WIDTH/MODULUS/SATURATE/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q     = WIDTH'(RESET_VAL);
  localparam bit               WRAP_MODE = (SATURATE == MODE_WRAP);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             limit;
  logic             step;

  assign limit    = (up_dn == DIR_UP) ? (q_q == MAX_VAL) : (q_q == '0);
  assign step     = en & ~clr & ~load;
  assign at_limit = limit;
  assign tc       = step & limit;

  always_comb begin
    q_d    = q_q;
    wrap_d = tc & WRAP_MODE;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      // Clamp keeps Q inside 0..MODULUS-1 whatever the loader supplies.
      q_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (limit) begin
        if (WRAP_MODE) begin
          q_d = (up_dn == DIR_UP) ? '0 : MAX_VAL;
        end
      end else begin
        q_d = (up_dn == DIR_UP) ? q_q + 1'b1 : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - directed table and sequence bench for mod_updown_counter
module tb_mod_updown_counter;
  import alarm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic       hr_clr = 1'b0, hr_load = 1'b0;
  logic [4:0] hr_load_val = '0;

  logic [5:0] a_q, b_q, d_q;
  logic [4:0] h_q;
  logic [1:0] e_q;
  logic a_tc, a_wrap, a_al, b_tc, b_wrap, b_al, d_tc, d_wrap, d_al;
  logic h_tc, h_wrap, h_al, e_tc, e_wrap, e_al;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(6), .MODULUS(SEC_MOD), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .Q(a_q), .tc(a_tc), .wrap(a_wrap), .at_limit(a_al));

  mod_updown_counter #(.WIDTH(6), .MODULUS(SEC_MOD), .SATURATE(MODE_SAT), .RESET_VAL(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .Q(b_q), .tc(b_tc), .wrap(b_wrap), .at_limit(b_al));

  mod_updown_counter #(.WIDTH(5), .MODULUS(HR_MOD), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_h (
    .clk(clk), .rst(rst), .en(a_tc), .up_dn(up_dn), .clr(hr_clr), .load(hr_load),
    .load_val(hr_load_val), .Q(h_q), .tc(h_tc), .wrap(h_wrap), .at_limit(h_al));

  mod_updown_counter #(.WIDTH(6), .MODULUS(SEC_MOD), .SATURATE(MODE_WRAP), .RESET_VAL(5)) u_d (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .Q(d_q), .tc(d_tc), .wrap(d_wrap), .at_limit(d_al));

  mod_updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_e (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val[1:0]),
    .Q(e_q), .tc(e_tc), .wrap(e_wrap), .at_limit(e_al));

  typedef struct packed {
    logic       clr;
    logic       load;
    logic [5:0] lv;
    logic       en;
    logic       ud;
    logic       e_al;
    logic       e_tc;
    logic [5:0] e_q;
    logic       e_wrap;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [5:0] lv, input logic e, input logic u);
    clr = c; load = l; load_val = lv; en = e; up_dn = u;
  endtask

  vec_t vecs [0:18];

  initial begin
    vecs = '{
      '{1'b0, 1'b1, 6'd58, 1'b0, 1'b1, 1'b0, 1'b0, 6'd58, 1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd59, 1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 1'b1, 6'd0,  1'b1},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd1,  1'b0},
      '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 1'b1, 6'd59, 1'b1},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'd58, 1'b0},
      '{1'b1, 1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0},
      '{1'b0, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0, 1'b0, 6'd59, 1'b0},
      '{1'b0, 1'b1, 6'd10, 1'b1, 1'b1, 1'b1, 1'b0, 6'd10, 1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 6'd9,  1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 6'd10, 1'b0},
      '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0},
      '{1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0},
      '{1'b0, 1'b1, 6'd59, 1'b0, 1'b1, 1'b0, 1'b0, 6'd59, 1'b0},
      '{1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 1'b1, 1'b1, 6'd0,  1'b1},
      '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0}
    };

    // Reset values
    #12;
    chk("rst_a_q", a_q, 0);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_d_q", d_q, 5);
    chk("rst_h_q", h_q, 0);
    chk("rst_e_q", e_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: up/down wrap, priority, clamp, hold, direction change
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].ud);
      #1;
      chk($sformatf("v%0d_at_limit", i), a_al, vecs[i].e_al);
      chk($sformatf("v%0d_tc", i), a_tc, vecs[i].e_tc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_q", i), a_q, vecs[i].e_q);
      chk($sformatf("v%0d_wrap", i), a_wrap, vecs[i].e_wrap);
    end

    // Saturate mode: hold at 0 counting down, hold at MODULUS-1 counting up
    @(negedge clk); drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
      #1;
      chk("sat_dn_al", b_al, 1);
      chk("sat_dn_tc", b_tc, 1);
      @(posedge clk); #1;
      chk("sat_dn_q", b_q, 0);
      chk("sat_dn_wrap", b_wrap, 0);
    end
    @(negedge clk); drive(1'b0, 1'b1, 6'd59, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
      #1;
      chk("sat_up_tc", b_tc, 1);
      @(posedge clk); #1;
      chk("sat_up_q", b_q, 59);
      chk("sat_up_wrap", b_wrap, 0);
    end

    // Cascade seconds -> hours from 59/23
    @(negedge clk);
    drive(1'b0, 1'b1, 6'd59, 1'b0, 1'b1);
    hr_load = 1'b1; hr_load_val = 5'd23;
    @(negedge clk);
    hr_load = 1'b0;
    chk("casc_pre_h_q", h_q, 23);
    drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    #1;
    chk("casc_a_tc", a_tc, 1);
    chk("casc_h_tc", h_tc, 1);
    @(posedge clk); #1;
    chk("casc_a_q", a_q, 0);
    chk("casc_h_q", h_q, 0);
    chk("casc_a_wrap", a_wrap, 1);
    chk("casc_h_wrap", h_wrap, 1);

    // Binary modulus 4: legacy 0,1,2,3,0 sequence
    @(negedge clk); drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bin_q0", e_q, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("bin_q%0d", i), e_q, i % 4);
      chk($sformatf("bin_wrap%0d", i), e_wrap, (i == 4) ? 1 : 0);
    end

    // Async reset between edges while wrap is high
    @(negedge clk); drive(1'b0, 1'b1, 6'd59, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("arst_pre_wrap", a_wrap, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_a_wrap", a_wrap, 0);
    chk("arst_d_q", d_q, 5);
    chk("arst_d_wrap", d_wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("arst_resume_d_q", d_q, 6);

    @(negedge clk); drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
